// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter: arbitrates NREQ requesters onto one shared register-file
// read port and registers the read data into a single response register.
//
// Optional build macro: RF_ARB_PRIO0_EN
//   undefined: round-robin over all requesters.
//   defined:   requester 0 has fixed priority (decode-stage read); the others
//              round-robin among themselves. Grants to requester 0 leave ptr
//              unchanged.
//
// Handshake: the response is a valid/ready channel. rsp_data and rsp_id are
// meaningful while rsp_valid is high. They hold steady until a cycle in which
// rsp_ready is high, and that cycle transfers the response. A new read is
// granted only when the response register is free or is being drained in
// the same cycle (!rsp_valid || rsp_ready). That allows one read per cycle
// back-to-back.
module rf_read_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   grant,
  output logic [4:0]        rf_sel,
  input  logic [DW-1:0]     rf_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic [IDW-1:0]    dbg_ptr
);

  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic           can_accept;
  logic           prio0;
  logic           rr_found;
  logic [IDW-1:0] rr_idx;
  logic [IDW:0]   cand;
  logic           win_valid;
  logic [IDW-1:0] win_idx;
  logic           move_ptr;
  logic [NREQ-1:0] grant_d;
  logic [4:0]     rf_sel_d;

  // The response register can take a new read when it is empty or draining now.
  assign can_accept = !rsp_valid_q || rsp_ready;

  // Fixed-priority override for requester 0 when the priority build is selected.
`ifdef RF_ARB_PRIO0_EN
  assign prio0 = req[0];
`else
  assign prio0 = 1'b0;
`endif

  // Round-robin search: first asserted req starting at ptr, wrapping modulo NREQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + k[IDW:0];
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!rr_found && req[cand[IDW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[IDW-1:0];
      end
    end
  end

  // Pick the winner. Reset and a stalled response suppress any grant.
  always_comb begin
    win_valid = !reset && can_accept && (prio0 || rr_found);
    win_idx   = prio0 ? '0 : rr_idx;
    move_ptr  = win_valid && !prio0;
  end

  // One-hot grant and the matching address for the shared read mux.
  always_comb begin
    grant_d  = '0;
    rf_sel_d = '0;
    if (win_valid) grant_d[win_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_d[i]) rf_sel_d = rf_sel_d | req_addr[5*i +: 5];
    end
  end

  assign grant  = grant_d;
  assign rf_sel = rf_sel_d;

  // Next pointer: one past the round-robin winner, wrapping at the last requester.
  always_comb begin
    ptr_d = ptr_q;
    if (move_ptr) ptr_d = (win_idx == LAST) ? '0 : win_idx + 1'b1;
  end

  // Response register next state: load on grant, clear valid on drain, else hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (win_valid) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rf_data;
      rsp_id_d    = win_idx;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed testbench for rf_read_arbiter (NREQ=4, DW=32).
// When RF_ARB_PRIO0_EN is defined, it runs the fixed-priority sequence in
// place of the pure round-robin sequence.
module tb_rf_read_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [19:0] req_addr;
  logic [3:0]  grant;
  logic [4:0]  rf_sel;
  logic [31:0] rf_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_id;
  logic [1:0]  dbg_ptr;

  logic [31:0] mem [32];
  logic [4:0]  addr_of [4];
  logic [31:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  rf_read_arbiter #(.NREQ(4), .DW(32)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .grant(grant), .rf_sel(rf_sel), .rf_data(rf_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .dbg_ptr(dbg_ptr)
  );

  // Clock and register-file mux bank model.
  always #5 clk = ~clk;
  assign rf_data  = mem[rf_sel];
  assign req_addr = {addr_of[3], addr_of[2], addr_of[1], addr_of[0]};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, cross the posedge.
  task automatic step(input string tag, input logic rst, input logic [3:0] r, input logic rdy,
                      input logic [3:0] eg, input logic [4:0] es);
    @(negedge clk);
    reset = rst; req = r; rsp_ready = rdy;
    #1;
    check_eq({tag, "/grant"}, {28'd0, grant}, {28'd0, eg});
    check_eq({tag, "/rf_sel"}, {27'd0, rf_sel}, {27'd0, es});
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [31:0] d,
                           input logic [1:0] id, input logic [1:0] p);
    check_eq({tag, "/rsp_valid"}, {31'd0, rsp_valid}, {31'd0, v});
    check_eq({tag, "/rsp_data"}, rsp_data, d);
    check_eq({tag, "/rsp_id"}, {30'd0, rsp_id}, {30'd0, id});
    check_eq({tag, "/ptr"}, {30'd0, dbg_ptr}, {30'd0, p});
  endtask

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  t1_ptr;
    logic [31:0] exp_d;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    mem[5] = 32'hDEAD_BEEF;
    mem[0] = 32'hC0DE_0000;
    addr_of[0] = 5'd5;
    addr_of[1] = 5'd9;
    addr_of[2] = 5'd0;
    addr_of[3] = 5'd31;
`ifdef RF_ARB_PRIO0_EN
    t1_ptr = 2'd0;
`else
    t1_ptr = 2'd1;
`endif

    // Reset with requests present: no grant, registers cleared.
    step("rst", 1'b1, 4'b1111, 1'b1, 4'b0000, 5'd0);
    check_rsp("rst", 1'b0, 32'h0, 2'd0, 2'd0);

    // Single read of address 5 from requester 0.
    step("single", 1'b0, 4'b0001, 1'b1, 4'b0001, 5'd5);
    check_rsp("single", 1'b1, 32'hDEAD_BEEF, 2'd0, t1_ptr);

    step("rst2", 1'b1, 4'b0000, 1'b1, 4'b0000, 5'd0);
    check_rsp("rst2", 1'b0, 32'h0, 2'd0, 2'd0);

`ifdef RF_ARB_PRIO0_EN
    // Requester 0 wins every cycle and leaves ptr alone.
    for (int k = 0; k < 4; k++) begin
      step("prio0", 1'b0, 4'b1111, 1'b1, 4'b0001, 5'd5);
      check_rsp("prio0", 1'b1, 32'hDEAD_BEEF, 2'd0, 2'd0);
    end
    // Without req[0] the rest rotate 1,2,3,1.
    begin
      logic [1:0] seq [4];
      seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd1;
      for (int k = 0; k < 4; k++) begin
        logic [3:0] g;
        g = 4'b0001 << seq[k];
        step("prio_rr", 1'b0, 4'b1110, 1'b1, g, addr_of[seq[k]]);
        check_rsp("prio_rr", 1'b1, mem[addr_of[seq[k]]], seq[k],
                  (seq[k] == 2'd3) ? 2'd0 : seq[k] + 2'd1);
      end
    end
    step("rst3", 1'b1, 4'b0000, 1'b1, 4'b0000, 5'd0);
`else
    // All requesting: strict rotation 0,1,2,3,... one response per cycle.
    for (int k = 0; k < 8; k++) begin
      logic [1:0] i;
      i = k[1:0];
      step("rr", 1'b0, 4'b1111, 1'b1, 4'b0001 << i, addr_of[i]);
      exp_q.push_back(mem[addr_of[i]]);
      exp_d = exp_q.pop_front();
      check_rsp("rr", 1'b1, exp_d, i, i + 2'd1);
    end
`endif

    // Stall: response held, no grant while rsp_ready is low.
    step("ld", 1'b0, 4'b0001, 1'b1, 4'b0001, 5'd5);
    check_eq("ld/rsp_data", rsp_data, 32'hDEAD_BEEF);
    for (int k = 0; k < 3; k++) begin
      step("stall", 1'b0, 4'b0110, 1'b0, 4'b0000, 5'd0);
      check_eq("stall/rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("stall/rsp_data", rsp_data, 32'hDEAD_BEEF);
      check_eq("stall/rsp_id", {30'd0, rsp_id}, 32'd0);
    end
    step("unstall", 1'b0, 4'b0110, 1'b1, 4'b0010, 5'd9);
    check_rsp("unstall", 1'b1, mem[9], 2'd1, 2'd2);

    // Drain with no request: valid falls, data and id hold.
    step("drain", 1'b0, 4'b0000, 1'b1, 4'b0000, 5'd0);
    check_rsp("drain", 1'b0, mem[9], 2'd1, 2'd2);

    // Grant to the last requester wraps ptr to 0.
    step("wrap", 1'b0, 4'b1000, 1'b1, 4'b1000, 5'd31);
    check_rsp("wrap", 1'b1, mem[31], 2'd3, 2'd0);

    // Requester 2 reads address 0, then reset discards the next grant.
    step("zero", 1'b0, 4'b0100, 1'b1, 4'b0100, 5'd0);
    check_rsp("zero", 1'b1, 32'hC0DE_0000, 2'd2, 2'd3);
    step("rst_inflight", 1'b1, 4'b0100, 1'b1, 4'b0000, 5'd0);
    check_rsp("rst_inflight", 1'b0, 32'h0, 2'd0, 2'd0);
    step("rereq", 1'b0, 4'b0100, 1'b1, 4'b0100, 5'd0);
    check_rsp("rereq", 1'b1, 32'hC0DE_0000, 2'd2, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
